// File: rtl/hci_tcdm_bank_arbiter_if.sv
// Bundle of the initiator-side and bank-side signals of one TCDM bank arbiter.
// Handshake: a transfer happens in every cycle where req and gnt are both high; req is a level and may change at any time.
interface hci_tcdm_bank_arbiter_if #(
    parameter int unsigned N_IN = 4,
    parameter int unsigned AW   = 32,
    parameter int unsigned AWM  = 10,
    parameter int unsigned DW   = 32,
    parameter int unsigned BW   = 8
);
    localparam int unsigned BEW = DW / BW;

    logic [N_IN-1:0]           in_req_i;
    logic [N_IN-1:0][AW-1:0]   in_add_i;
    logic [N_IN-1:0]           in_wen_i;
    logic [N_IN-1:0][DW-1:0]   in_wdata_i;
    logic [N_IN-1:0][BEW-1:0]  in_be_i;
    logic [N_IN-1:0]           in_gnt_o;
    logic [N_IN-1:0]           r_valid_o;
    logic [DW-1:0]             r_data_o;

    logic                      mem_req_o;
    logic [AWM-1:0]            mem_add_o;
    logic                      mem_wen_o;
    logic [DW-1:0]             mem_wdata_o;
    logic [BEW-1:0]            mem_be_o;
    logic                      mem_gnt_i;
    logic [DW-1:0]             mem_r_data_i;

    modport slave (
        input  in_req_i, in_add_i, in_wen_i, in_wdata_i, in_be_i, mem_gnt_i, mem_r_data_i,
        output in_gnt_o, r_valid_o, r_data_o, mem_req_o, mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o
    );

    modport master (
        output in_req_i, in_add_i, in_wen_i, in_wdata_i, in_be_i, mem_gnt_i, mem_r_data_i,
        input  in_gnt_o, r_valid_o, r_data_o, mem_req_o, mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o
    );
endinterface

// File: rtl/hci_tcdm_bank_arbiter.sv
// Per-bank arbiter: round-robin / fixed-priority selection of N_IN initiators onto one SRAM bank,
// with an in-order response pipeline of depth MEM_LAT and a blocking test-and-set write-back.
module hci_tcdm_bank_arbiter #(
    parameter int unsigned N_IN    = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned AWM     = 10,
    parameter int unsigned DW      = 32,
    parameter int unsigned BW      = 8,
    parameter int unsigned TS_BIT  = 21,
    parameter int unsigned MEM_LAT = 1,
    localparam int unsigned PW     = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int unsigned BEW    = DW / BW
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   arb_policy_i,
    hci_tcdm_bank_arbiter_if.slave bus,
    output logic                   dbg_ts_wr_o,
    output logic [PW-1:0]          dbg_rr_ptr_o
);
    typedef enum logic {IDLE = 1'b0, TS_WR = 1'b1} state_t;

    state_t                       state_q, state_d;
    logic [PW-1:0]                ptr_q, ptr_d;
    logic [AWM-1:0]               ts_add_q, ts_add_d;

    logic                         win_found;
    logic [PW-1:0]                win_idx;
    logic                         issue, issue_rd;
    logic [N_IN-1:0]              gnt;
    logic                         mem_req, mem_wen;
    logic [AWM-1:0]               mem_add;
    logic [DW-1:0]                mem_wdata;
    logic [BEW-1:0]               mem_be;
    logic [N_IN-1:0]              r_valid;

    logic [MEM_LAT-1:0]           rsp_vld_q, rsp_rd_q;
    logic [MEM_LAT-1:0][PW-1:0]   rsp_idx_q;

    // Address bits outside the word index and the TS bit carry no meaning for this bank.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.in_add_i;

    function automatic logic [PW-1:0] cand_idx(input logic [PW-1:0] p, input logic fixed,
                                               input int unsigned k);
        int unsigned s;
        s = fixed ? k : (32'(p) + k) % N_IN;
        return PW'(s);
    endfunction

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (!win_found && bus.in_req_i[cand_idx(ptr_q, arb_policy_i, k)]) begin
                win_found = 1'b1;
                win_idx   = cand_idx(ptr_q, arb_policy_i, k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ts_add_d  = ts_add_q;
        gnt       = '0;
        mem_req   = 1'b0;
        mem_add   = '0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        mem_be    = '0;
        issue     = 1'b0;
        issue_rd  = 1'b0;
        case (state_q)
            IDLE: begin
                mem_req = |bus.in_req_i;
                if (win_found) begin
                    mem_add      = bus.in_add_i[win_idx][AWM+1:2];
                    mem_wen      = bus.in_wen_i[win_idx];
                    mem_wdata    = bus.in_wdata_i[win_idx];
                    mem_be       = bus.in_be_i[win_idx];
                    gnt[win_idx] = bus.mem_gnt_i;
                    if (bus.mem_gnt_i) begin
                        issue    = 1'b1;
                        issue_rd = bus.in_wen_i[win_idx];
                        if (!arb_policy_i) begin
                            ptr_d = (win_idx == PW'(N_IN - 1)) ? '0 : win_idx + 1'b1;
                        end
                        // A read of the TS alias returns the old word and must be followed by an all-ones write.
                        if (bus.in_wen_i[win_idx] && bus.in_add_i[win_idx][TS_BIT]) begin
                            state_d  = TS_WR;
                            ts_add_d = bus.in_add_i[win_idx][AWM+1:2];
                        end
                    end
                end
            end
            TS_WR: begin
                mem_req   = 1'b1;
                mem_add   = ts_add_q;
                mem_wen   = 1'b0;
                mem_wdata = '1;
                mem_be    = '1;
                if (bus.mem_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            ts_add_q  <= '0;
            rsp_vld_q <= '0;
            rsp_rd_q  <= '0;
            rsp_idx_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ts_add_q     <= ts_add_d;
            rsp_vld_q[0] <= issue;
            rsp_rd_q[0]  <= issue_rd;
            rsp_idx_q[0] <= win_idx;
            for (int i = 1; i < int'(MEM_LAT); i++) begin
                rsp_vld_q[i] <= rsp_vld_q[i-1];
                rsp_rd_q[i]  <= rsp_rd_q[i-1];
                rsp_idx_q[i] <= rsp_idx_q[i-1];
            end
        end
    end

    always_comb begin
        r_valid = '0;
        if (rsp_vld_q[MEM_LAT-1]) begin
            r_valid[rsp_idx_q[MEM_LAT-1]] = 1'b1;
        end
    end

    assign bus.in_gnt_o    = gnt;
    assign bus.r_valid_o   = r_valid;
    assign bus.r_data_o    = (rsp_vld_q[MEM_LAT-1] && rsp_rd_q[MEM_LAT-1]) ? bus.mem_r_data_i : '0;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_add_o   = mem_add;
    assign bus.mem_wen_o   = mem_wen;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.mem_be_o    = mem_be;
    assign dbg_ts_wr_o     = (state_q == TS_WR);
    assign dbg_rr_ptr_o    = ptr_q;
endmodule

// File: tb/tb_hci_tcdm_bank_arbiter.sv
// Bench for hci_tcdm_bank_arbiter: two instances (MEM_LAT 1 and 3) share one stimulus stream,
// a reference arbitration model and per-latency expected-response queues.
module tb_hci_tcdm_bank_arbiter;
    localparam int unsigned N_IN = 4, AW = 32, AWM = 10, DW = 32, BW = 8, BEW = DW / BW, TS_BIT = 21;
    localparam int unsigned QW = 50;  // {due[15:0], idx[1:0], data[31:0]}

    logic clk = 1'b0;
    logic rst, pol, mgnt;
    logic [N_IN-1:0]          req, wen;
    logic [N_IN-1:0][AW-1:0]  add;
    logic [N_IN-1:0][DW-1:0]  wdata;
    logic [N_IN-1:0][BEW-1:0] be;

    always #5 clk = ~clk;

    hci_tcdm_bank_arbiter_if #(.N_IN(N_IN), .AW(AW), .AWM(AWM), .DW(DW), .BW(BW)) if1 ();
    hci_tcdm_bank_arbiter_if #(.N_IN(N_IN), .AW(AW), .AWM(AWM), .DW(DW), .BW(BW)) if3 ();

    logic            o_ts[2];
    logic [1:0]      o_ptr[2];
    logic [DW-1:0]   dl[2][4];
    logic [DW-1:0]   bank_mem[2][1024];
    logic [DW-1:0]   ref_mem[1024];

    assign if1.in_req_i = req;    assign if3.in_req_i = req;
    assign if1.in_add_i = add;    assign if3.in_add_i = add;
    assign if1.in_wen_i = wen;    assign if3.in_wen_i = wen;
    assign if1.in_wdata_i = wdata; assign if3.in_wdata_i = wdata;
    assign if1.in_be_i = be;      assign if3.in_be_i = be;
    assign if1.mem_gnt_i = mgnt;  assign if3.mem_gnt_i = mgnt;
    assign if1.mem_r_data_i = dl[0][0];
    assign if3.mem_r_data_i = dl[1][2];

    hci_tcdm_bank_arbiter #(.N_IN(N_IN), .AW(AW), .AWM(AWM), .DW(DW), .BW(BW), .TS_BIT(TS_BIT), .MEM_LAT(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .arb_policy_i(pol), .bus(if1.slave),
        .dbg_ts_wr_o(o_ts[0]), .dbg_rr_ptr_o(o_ptr[0])
    );
    hci_tcdm_bank_arbiter #(.N_IN(N_IN), .AW(AW), .AWM(AWM), .DW(DW), .BW(BW), .TS_BIT(TS_BIT), .MEM_LAT(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .arb_policy_i(pol), .bus(if3.slave),
        .dbg_ts_wr_o(o_ts[1]), .dbg_rr_ptr_o(o_ptr[1])
    );

    logic [N_IN-1:0] o_gnt[2], o_rv[2];
    logic [DW-1:0]   o_rd[2], o_wd[2];
    logic            o_req[2], o_wen[2];
    logic [AWM-1:0]  o_add[2];
    logic [BEW-1:0]  o_be[2];
    assign o_gnt[0] = if1.in_gnt_o;    assign o_gnt[1] = if3.in_gnt_o;
    assign o_rv[0]  = if1.r_valid_o;   assign o_rv[1]  = if3.r_valid_o;
    assign o_rd[0]  = if1.r_data_o;    assign o_rd[1]  = if3.r_data_o;
    assign o_wd[0]  = if1.mem_wdata_o; assign o_wd[1]  = if3.mem_wdata_o;
    assign o_req[0] = if1.mem_req_o;   assign o_req[1] = if3.mem_req_o;
    assign o_wen[0] = if1.mem_wen_o;   assign o_wen[1] = if3.mem_wen_o;
    assign o_add[0] = if1.mem_add_o;   assign o_add[1] = if3.mem_add_o;
    assign o_be[0]  = if1.mem_be_o;    assign o_be[1]  = if3.mem_be_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int m_ptr;
    logic m_ts;
    logic [AWM-1:0] m_ts_add;
    logic [QW-1:0] exp_q1[$];
    logic [QW-1:0] exp_q3[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic string tg(input string n, input int d);
        return $sformatf("%s_lat%0d", n, (d == 0) ? 1 : 3);
    endfunction

    function automatic logic [DW-1:0] init_word(input int unsigned w);
        if (w == 5) return 32'h0000_0000;
        if (w == 7) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + w;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BEW-1:0] b);
        logic [DW-1:0] r;
        r = old;
        for (int k = 0; k < int'(BEW); k++) if (b[k]) r[k*8 +: 8] = nw[k*8 +: 8];
        return r;
    endfunction

    task automatic resp_check(input int d, input logic hit, input logic [QW-1:0] ent);
        logic [N_IN-1:0] ev;
        ev = '0;
        if (hit) ev[ent[33:32]] = 1'b1;
        check(tg("r_valid", d), 64'(o_rv[d]), 64'(ev));
        check(tg("r_data", d), 64'(o_rd[d]), hit ? 64'(ent[31:0]) : 64'h0);
    endtask

    // Reference model, scoreboard and bank model: evaluate at negedge, commit state at posedge.
    initial begin : monitor
        logic [N_IN-1:0] e_gnt;
        logic            e_req, e_wen, hs, found, hit;
        logic [AWM-1:0]  e_add;
        logic [DW-1:0]   e_wd, e_dat;
        logic [BEW-1:0]  e_be;
        logic [QW-1:0]   ent;
        int              w, cand;
        logic            bk_hs[2], bk_wen[2];
        logic [AWM-1:0]  bk_add[2];
        logic [DW-1:0]   bk_wd[2];
        logic [BEW-1:0]  bk_be[2];
        for (int a = 0; a < 1024; a++) begin
            ref_mem[a]     = init_word(a);
            bank_mem[0][a] = init_word(a);
            bank_mem[1][a] = init_word(a);
        end
        for (int d = 0; d < 2; d++) for (int s = 0; s < 4; s++) dl[d][s] = '0;
        m_ptr = 0; m_ts = 1'b0; m_ts_add = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_gnt = '0; e_req = 1'b0; e_add = '0; e_wen = 1'b0; e_wd = '0; e_be = '0;
            hs = 1'b0; found = 1'b0; w = 0;
            if (m_ts) begin
                e_req = 1'b1; e_add = m_ts_add; e_wd = '1; e_be = '1; hs = mgnt;
            end else begin
                e_req = |req;
                for (int o = 0; o < int'(N_IN); o++) begin
                    cand = pol ? o : (m_ptr + o) % int'(N_IN);
                    if (!found && req[cand]) begin found = 1'b1; w = cand; end
                end
                if (found) begin
                    e_add = add[w][AWM+1:2]; e_wen = wen[w]; e_wd = wdata[w]; e_be = be[w];
                    e_gnt[w] = mgnt; hs = mgnt;
                end
            end
            for (int d = 0; d < 2; d++) begin
                check(tg("in_gnt", d), 64'(o_gnt[d]), 64'(e_gnt));
                check(tg("mem_req", d), 64'(o_req[d]), 64'(e_req));
                check(tg("mem_add", d), 64'(o_add[d]), 64'(e_add));
                check(tg("mem_wen", d), 64'(o_wen[d]), 64'(e_wen));
                check(tg("mem_wdata", d), 64'(o_wd[d]), 64'(e_wd));
                check(tg("mem_be", d), 64'(o_be[d]), 64'(e_be));
                check(tg("fsm_ts", d), 64'(o_ts[d]), 64'(m_ts));
                check(tg("rr_ptr", d), 64'(o_ptr[d]), 64'(m_ptr));
                bk_hs[d] = o_req[d] && mgnt; bk_wen[d] = o_wen[d]; bk_add[d] = o_add[d];
                bk_wd[d] = o_wd[d]; bk_be[d] = o_be[d];
            end
            hit = (exp_q1.size() > 0) && (exp_q1[0][49:34] == 16'(cyc));
            ent = hit ? exp_q1.pop_front() : '0;
            resp_check(0, hit, ent);
            hit = (exp_q3.size() > 0) && (exp_q3[0][49:34] == 16'(cyc));
            ent = hit ? exp_q3.pop_front() : '0;
            resp_check(1, hit, ent);
            if (hs && !m_ts) begin
                e_dat = wen[w] ? ref_mem[e_add] : '0;
                exp_q1.push_back({16'(cyc + 1), 2'(w), e_dat});
                exp_q3.push_back({16'(cyc + 3), 2'(w), e_dat});
                if (!wen[w]) ref_mem[e_add] = merge(ref_mem[e_add], wdata[w], be[w]);
            end else if (hs && m_ts) begin
                ref_mem[m_ts_add] = '1;
            end
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int s = 3; s > 0; s--) dl[d][s] = dl[d][s-1];
                dl[d][0] = 32'h0BAD_0BAD;
                if (bk_hs[d]) begin
                    if (bk_wen[d]) dl[d][0] = bank_mem[d][bk_add[d]];
                    else bank_mem[d][bk_add[d]] = merge(bank_mem[d][bk_add[d]], bk_wd[d], bk_be[d]);
                end
            end
            if (rst) begin
                m_ptr = 0; m_ts = 1'b0; m_ts_add = '0;
                exp_q1.delete(); exp_q3.delete();
            end else if (hs) begin
                if (m_ts) m_ts = 1'b0;
                else begin
                    if (!pol) m_ptr = (w + 1) % int'(N_IN);
                    if (wen[w] && add[w][TS_BIT]) begin m_ts = 1'b1; m_ts_add = e_add; end
                end
            end
            cyc++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        req = '0; wen = '0; add = '0; wdata = '0; be = '0;
    endtask

    task automatic set_port(input int i, input logic rd, input int unsigned word, input logic ts,
                            input logic [DW-1:0] d, input logic [BEW-1:0] b);
        req[i] = 1'b1; wen[i] = rd; wdata[i] = d; be[i] = b;
        add[i] = (32'(ts) << TS_BIT) | (word << 2);
    endtask

    initial begin : driver
        rst = 1'b1; pol = 1'b0; mgnt = 1'b1; idle_ports();
        next_cycle(); next_cycle();
        rst = 1'b0;
        next_cycle();
        // Round-robin with all ports reading continuously.
        for (int i = 0; i < int'(N_IN); i++) set_port(i, 1'b1, 16 + i, 1'b0, '0, '1);
        repeat (8) next_cycle();
        // Move the pointer to 2, then fixed priority between ports 1 and 3, then back to RR.
        idle_ports(); set_port(1, 1'b0, 20, 1'b0, 32'hCAFE_0001, 4'b0011); next_cycle();
        idle_ports(); pol = 1'b1;
        set_port(1, 1'b1, 21, 1'b0, '0, '1); set_port(3, 1'b1, 22, 1'b0, '0, '1);
        repeat (3) next_cycle();
        pol = 1'b0; next_cycle();
        idle_ports(); next_cycle();
        // Test-and-set from port 2 on word 5 while port 0 waits.
        set_port(2, 1'b1, 5, 1'b1, '0, '1); next_cycle();
        idle_ports(); set_port(0, 1'b0, 9, 1'b0, 32'h1234_5678, '1);
        repeat (2) next_cycle();
        idle_ports(); next_cycle();
        // Bank stall during the write-back.
        set_port(1, 1'b1, 6, 1'b1, '0, '1); next_cycle();
        idle_ports(); set_port(3, 1'b1, 7, 1'b0, '0, '1); mgnt = 1'b0;
        repeat (3) next_cycle();
        mgnt = 1'b1; repeat (2) next_cycle();
        idle_ports(); next_cycle();
        // Alternating write (port 0) and read of 0xDEADBEEF (port 1).
        set_port(0, 1'b0, 12, 1'b0, 32'hA5A5_0F0F, '1); set_port(1, 1'b1, 7, 1'b0, '0, '1);
        repeat (6) next_cycle();
        idle_ports(); repeat (4) next_cycle();
        // Randomised traffic, stalls and policy flips.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < int'(N_IN); i++) begin
                req[i]   = ($urandom_range(0, 3) != 0);
                wen[i]   = 1'($urandom_range(0, 1));
                add[i]   = ($urandom & 32'hFFDF_F000) | (($urandom_range(0, 7) == 0) ? (32'h1 << TS_BIT) : 32'h0)
                           | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                wdata[i] = $urandom;
                be[i]    = 4'($urandom_range(0, 15));
            end
            pol  = ($urandom_range(0, 3) == 0);
            mgnt = ($urandom_range(0, 3) != 0);
            next_cycle();
        end
        idle_ports(); pol = 1'b0; mgnt = 1'b1; repeat (5) next_cycle();
        // Reset while reads are in flight and the FSM sits in TS_WR.
        set_port(0, 1'b1, 7, 1'b0, '0, '1); next_cycle();
        idle_ports(); set_port(1, 1'b1, 3, 1'b1, '0, '1); next_cycle();
        idle_ports(); mgnt = 1'b0; rst = 1'b1; next_cycle();
        rst = 1'b0; mgnt = 1'b1;
        repeat (6) next_cycle();
        check("q1_drained", 64'(exp_q1.size()), 64'h0);
        check("q3_drained", 64'(exp_q3.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
